// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock over a precomputed key schedule.
// Optional build macro AES_INV_KEY_LATCH_EN captures the key schedule at accept.
module aes_inv_cipher_iter #(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          ciphertext,
    input  logic [128*(NR+1)-1:0] key_schedule,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          plaintext,
    output logic                  busy
);

    localparam int KW = 128 * (NR + 1);
    localparam int RW = $clog2(NR + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [RW-1:0]   rnd_r;
    logic [127:0]    st_r, pt_r, rk_s, round_s;
    logic            out_valid_r, in_ready_r, busy_r, accept_s;
    logic [KW-1:0]   key_src_s;
    logic [127:0]    rk_arr_s [0:NR];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            else      p = p;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(gmul(gmul(x15, x15), gmul(x15, x15)), gmul(gmul(x15, x15), gmul(x15, x15)));
        x240 = gmul(x240, x240);
        return gmul(gmul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] a;
        a = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return ginv(a);
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic mix);
        logic [7:0]   b [0:3][0:3];
        logic [7:0]   m [0:3];
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b[r][c] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]) ^ rk[127-8*(4*c+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (mix) m[r] = gmul(8'h0e, b[r][c]) ^ gmul(8'h0b, b[(r+1)%4][c])
                              ^ gmul(8'h0d, b[(r+2)%4][c]) ^ gmul(8'h09, b[(r+3)%4][c]);
                else     m[r] = b[r][c];
                o[127-8*(4*c+r) -: 8] = m[r];
            end
        end
        return o;
    endfunction

`ifdef AES_INV_KEY_LATCH_EN
    logic [KW-1:0] key_r;

    // Private copy of the schedule so the port is free once a block is accepted
    always_ff @(posedge clk) begin
        if (!rst_n)        key_r <= '0;
        else if (accept_s) key_r <= key_schedule;
        else               key_r <= key_r;
    end
    assign key_src_s = key_r;
`else
    assign key_src_s = key_schedule;
`endif

    for (genvar k = 0; k <= NR; k++) begin : g_rk
        assign rk_arr_s[k] = key_src_s[KW-1-128*k -: 128];
    end

    assign rk_s    = rk_arr_s[rnd_r];
    assign round_s = inv_round(st_r, rk_s, rnd_r != '0);

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ROUND;
                    accept_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ROUND: begin
                if (rnd_r == '0) state_nxt_s = DONE;
                else             state_nxt_s = ROUND;
            end
            DONE: begin
                if (out_ready) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, round datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rnd_r       <= '0;
            st_r        <= 128'h0;
            pt_r        <= 128'h0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s == IDLE);
            busy_r     <= (state_nxt_s != IDLE);
            if (accept_s) begin
                st_r  <= ciphertext ^ key_schedule[127:0];
                rnd_r <= RW'(NR - 1);
            end else if (state_r == ROUND) begin
                st_r <= round_s;
                if (rnd_r != '0) rnd_r <= rnd_r - RW'(1);
            end
            if (state_r == ROUND && rnd_r == '0) begin
                pt_r        <= round_s;
                out_valid_r <= 1'b1;
            end else if (state_r == DONE && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign plaintext = pt_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter using FIPS-197 vectors; key schedules are
// expanded here from the cipher keys.
module tb_aes_inv_cipher_iter;

    localparam int NR = 10;
    localparam int KW = 128 * (NR + 1);

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0]  ciphertext, plaintext;
    logic [KW-1:0] key_schedule, ks1, ks2;

    int n_total = 0, n_pass = 0, n_out = 0, n_issued = 0;
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    aes_inv_cipher_iter #(.NR(NR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ciphertext(ciphertext), .key_schedule(key_schedule), .out_valid(out_valid),
        .out_ready(out_ready), .plaintext(plaintext), .busy(busy)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gm(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [KW-1:0] expand(input logic [127:0] key);
        logic [31:0]   w [0:43];
        logic [31:0]   t;
        logic [7:0]    rcon = 8'h01;
        logic [KW-1:0] ks;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[KW-1-32*i -: 32] = w[i];
        return ks;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic push(input logic [127:0] exp);
        exp_q.push_back(exp);
        n_issued++;
    endtask

    // Monitor: every completed output handshake is compared against the scoreboard
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL extra_output: got %h with nothing expected", plaintext);
            end else begin
                check("plaintext", plaintext, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [127:0] ct, input logic [KW-1:0] ks, input logic [127:0] exp);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ciphertext   = ct;
                key_schedule = ks;
                in_valid     = 1'b1;
                push(exp);
                @(posedge clk);
                #1 in_valid = 1'b0;
                return;
            end
        end
        timeout("send");
    endtask

    task automatic wait_out(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        timeout(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int edges;
        ks1 = expand(K1);
        ks2 = expand(K2);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ciphertext = 128'h0; key_schedule = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  128'(in_ready),  128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_plaintext", plaintext,        128'h0);
        check("rst_busy",      128'(busy),      128'd0);

        // Vector C.1 with latency measured in edges, accept edge counted as the first
        send(C1, ks1, P1);
        edges = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0) check("busy_round", 128'(busy), 128'd1);
            if (out_valid) break;
            @(posedge clk);
            edges++;
        end
        check("latency_edges", 128'(edges), 128'd11);
        @(posedge clk); #1;

        send(C2, ks2, P2);
        wait_out("vec2");
        @(posedge clk); #1;

        // Backpressure in DONE
        out_ready = 1'b0;
        send(C1, ks1, P1);
        wait_out("bp");
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_plaintext", plaintext, P1);
            check("bp_in_ready",  128'(in_ready), 128'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_pre", 128'(in_ready), 128'd0);
        @(negedge clk);
        check("bp_in_ready_post",  128'(in_ready),  128'd1);
        check("bp_out_valid_post", 128'(out_valid), 128'd0);

        // Back-to-back with in_valid held high and pulsed during ROUND
        @(posedge clk);
        #1 ciphertext = C1; key_schedule = ks1; in_valid = 1'b1;
        @(negedge clk);
        if (in_ready) push(P1);
        else timeout("b2b_accept1");
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1 in_valid = ~in_valid;
            @(negedge clk);
            check("b2b_in_ready_round", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b1;
        wait_out("b2b_out1");
        @(posedge clk);
        #1 ciphertext = C2; key_schedule = ks2;
        @(negedge clk);
        check("b2b_in_ready_idle", 128'(in_ready), 128'd1);
        push(P2);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out("b2b_out2");
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #1;

        // Reset in the middle of a block
        send(C1, ks1, P1);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        n_issued -= exp_q.size();
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_plaintext", plaintext,        128'h0);
        check("mid_rst_in_ready",  128'(in_ready),  128'd1);
        check("mid_rst_busy",      128'(busy),      128'd0);
        send(C2, ks2, P2);
        wait_out("post_rst");
        @(posedge clk); #1;

`ifdef AES_INV_KEY_LATCH_EN
        send(C1, ks1, P1);
        key_schedule = '1;
        wait_out("latch");
        @(posedge clk); #1;
`endif

        repeat (20) @(posedge clk);
        @(negedge clk);
        check("output_count",     128'(n_out),        128'(n_issued));
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
